apa102_frame_engine: RTL



---
 rtl/apa102_frame_engine.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/apa102_frame_engine.sv
// APA102 strand driver: on start, serialises one frame (zero start word, one LED word
// per pixel fetched from an external pixel store, then all-ones end words).
module apa102_frame_engine #(
    parameter int NUM_LEDS  = 12,
    parameter int HALF_DIV  = 256,
    parameter int END_WORDS = 1,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          blank,
    output logic          busy,
    output logic          done,
    output logic          pix_rd,
    output logic [AW-1:0] pix_addr,
    input  logic [28:0]   pix_data,
    output logic          sck,
    output logic          mosi
);

    typedef enum logic [1:0] {IDLE, START_W, LED_W, END_W} state_t;

    localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int WORD_MAX = (NUM_LEDS > END_WORDS) ? NUM_LEDS : END_WORDS;
    localparam int WC_W     = $clog2(WORD_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(HALF_DIV - 1);
    localparam logic [WC_W-1:0]  LED_LAST   = WC_W'(NUM_LEDS - 1);
    localparam logic [WC_W-1:0]  END_LAST   = WC_W'(END_WORDS - 1);
    localparam logic [AW:0]      ADDR_LAST  = (AW + 1)'(NUM_LEDS - 1);
    localparam logic [31:0]      BLANK_WORD = 32'hE000_0000;
    localparam logic [31:0]      ONES_WORD  = 32'hFFFF_FFFF;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic             sck_q;
    logic [4:0]       bit_cnt;
    logic [WC_W-1:0]  word_cnt;
    logic [31:0]      shift_reg;
    logic [31:0]      next_word;
    logic             blank_q;
    logic             pix_rd_d;
    logic             bit_end;
    logic             word_end;
    logic             fetch_more;

    // A bit ends on the last clk of its sck-high phase.
    assign bit_end    = sck_q && (div_cnt == DIV_LAST);
    assign word_end   = bit_end && (bit_cnt == 5'd0);
    assign fetch_more = ({1'b0, pix_addr} < ADDR_LAST);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = START_W;
            START_W: if (word_end) state_next = LED_W;
            LED_W:   if (word_end && (word_cnt == LED_LAST)) state_next = END_W;
            END_W:   if (word_end && (word_cnt == END_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        sck  = sck_q;
        mosi = shift_reg[31];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            sck_q     <= 1'b0;
            bit_cnt   <= 5'd0;
            word_cnt  <= '0;
            shift_reg <= '0;
            next_word <= '0;
            blank_q   <= 1'b0;
            pix_rd    <= 1'b0;
            pix_rd_d  <= 1'b0;
            pix_addr  <= '0;
            done      <= 1'b0;
        end else begin
            pix_rd   <= 1'b0;
            pix_rd_d <= pix_rd;
            done     <= (state != IDLE) && (state_next == IDLE);

            // Read data is valid the clk after the strobe, for both store styles.
            if (pix_rd_d) begin
                next_word <= {3'b111, pix_data};
            end

            if (state == IDLE) begin
                if (start) begin
                    blank_q   <= blank;
                    div_cnt   <= '0;
                    sck_q     <= 1'b0;
                    bit_cnt   <= 5'd31;
                    word_cnt  <= '0;
                    shift_reg <= '0;
                    if (!blank) begin
                        pix_rd   <= 1'b1;
                        pix_addr <= '0;
                    end
                end
            end else if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                sck_q   <= ~sck_q;
                if (sck_q) begin
                    if (bit_cnt != 5'd0) begin
                        bit_cnt   <= bit_cnt - 5'd1;
                        shift_reg <= {shift_reg[30:0], 1'b0};
                    end else begin
                        bit_cnt  <= 5'd31;
                        word_cnt <= (state_next != state) ? '0 : word_cnt + 1'b1;
                        case (state_next)
                            LED_W: begin
                                shift_reg <= blank_q ? BLANK_WORD : next_word;
                                // Entering LED word k (pix_addr == k): prefetch k+1.
                                if (!blank_q && fetch_more) begin
                                    pix_rd   <= 1'b1;
                                    pix_addr <= pix_addr + 1'b1;
                                end
                            end
                            END_W:   shift_reg <= ONES_WORD;
                            default: shift_reg <= '0;
                        endcase
                    end
                end
            end
        end
    end

endmodule
